// File: rtl/posit_pkg.sv
// Shared posit (N=32, es=2) constants, helpers and the unpacked operand format.
package posit_pkg;

    // Ceiling log2, used for widths derived from the posit size
    function automatic int unsigned log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    localparam int unsigned N  = 32;
    localparam int unsigned ES = 2;
    localparam int unsigned BS = log2(N);
    localparam int unsigned SW = BS + ES + 1;
    localparam int unsigned MW = N - ES - 2;

    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    // Decoded operand as consumed by the multiplier datapath
    typedef struct packed {
        logic                 sign;
        logic                 zero;
        logic                 inf;
        logic signed [SW-1:0] scale;
        logic [MW-1:0]        mant;
    } posit_unpacked_t;

endpackage

// File: rtl/posit_decode_pipe_if.sv
// Handshake bus of the posit decoder: raw posit in, decoded fields out.
interface posit_decode_pipe_if;
    import posit_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [N-1:0]         in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sign;
    logic                 out_zero;
    logic                 out_inf;
    logic signed [SW-1:0] out_scale;
    logic [MW-1:0]        out_mant;

    // Decoder side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_zero, out_inf, out_scale, out_mant
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_zero, out_inf, out_scale, out_mant
    );

endinterface

// File: rtl/posit_run_count.sv
// Leading identical-bit counter over the N-1 bits below the sign; reports run length and polarity.
module posit_run_count
    import posit_pkg::*;
(
    input  logic [N-2:0]  bits_i,
    output logic [BS-1:0] run_o,
    output logic          pol_o
);

    logic [N-2:0] inv;
    logic         found;

    // Invert a leading-ones run so both polarities reduce to counting leading zeros
    always_comb begin
        pol_o = bits_i[N-2];
        inv   = pol_o ? ~bits_i : bits_i;
        run_o = BS'(N - 1);
        found = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!found && inv[i]) begin
                run_o = BS'(N - 2 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/posit_decode_pipe.sv
// Two-stage pipelined posit decoder: S1 takes sign/magnitude, S2 extracts regime, exponent and fraction.
module posit_decode_pipe
    import posit_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    posit_decode_pipe_if.slave  bus
);

    // Stage 1: sign, magnitude below the sign bit, special flags
    logic         s1_valid_q, s1_valid_d;
    logic         s1_sign_q,  s1_sign_d;
    logic [N-2:0] s1_abs_q,   s1_abs_d;
    logic         s1_zero_q,  s1_zero_d;
    logic         s1_inf_q,   s1_inf_d;

    // Stage 2: decoded operand
    logic            s2_valid_q, s2_valid_d;
    posit_unpacked_t s2_q,       s2_d;

    logic s1_adv;
    logic s2_adv;

    // Regime decode helpers
    logic [BS-1:0]       rc_run;
    logic                rc_pol;
    logic [BS:0]         shamt;
    logic [N-2:0]        after_regime;
    logic [ES+MW-2:0]    exp_frac;
    logic [ES-1:0]       exp_bits;
    logic [MW-2:0]       frac_bits;
    logic [SW-1:0]       run_w;
    logic [SW-1:0]       k_w;
    posit_unpacked_t     dec;

    // Pipeline advance: a stage moves when it is empty or its consumer takes its word
    always_comb begin
        s2_adv = !s2_valid_q || bus.out_ready;
        s1_adv = !s1_valid_q || s2_adv;
    end

    assign bus.in_ready = s1_adv;

    // S1 capture: sign split and magnitude (low bits of the two's complement suffice)
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_abs_d   = s1_abs_q;
        s1_zero_d  = s1_zero_q;
        s1_inf_d   = s1_inf_q;
        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_d = bus.in_data[N-1];
                s1_abs_d  = bus.in_data[N-1] ? ((N-1)'(~bus.in_data[N-2:0]) + (N-1)'(1))
                                             : bus.in_data[N-2:0];
                s1_zero_d = (bus.in_data == '0);
                s1_inf_d  = (bus.in_data == NAR);
            end
        end
    end

    posit_run_count u_run_count (
        .bits_i (s1_abs_q),
        .run_o  (rc_run),
        .pol_o  (rc_pol)
    );

    // S2 decode: drop regime plus terminator, then exponent and fraction are left-aligned
    always_comb begin
        shamt        = {1'b0, rc_run} + (BS+1)'(1);
        after_regime = s1_abs_q << shamt;
        exp_frac     = (ES+MW-1)'(after_regime >> 2);
        exp_bits     = exp_frac[ES+MW-2 -: ES];
        frac_bits    = exp_frac[MW-2:0];
        run_w        = SW'(rc_run);
        k_w          = rc_pol ? (run_w - SW'(1)) : (SW'(0) - run_w);

        dec       = '0;
        dec.sign  = s1_sign_q;
        dec.zero  = s1_zero_q;
        dec.inf   = s1_inf_q;
        dec.scale = signed'((k_w << ES) + SW'(exp_bits));
        dec.mant  = {1'b1, frac_bits};
        if (s1_zero_q || s1_inf_q) begin
            dec.sign  = 1'b0;
            dec.scale = '0;
            dec.mant  = '0;
        end
    end

    // S2 capture: hold while the consumer stalls
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) s2_d = dec;
        end
    end

    // Pipeline registers; reset discards any in-flight words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_abs_q   <= '0;
            s1_zero_q  <= 1'b0;
            s1_inf_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_abs_q   <= s1_abs_d;
            s1_zero_q  <= s1_zero_d;
            s1_inf_q   <= s1_inf_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_sign  = s2_q.sign;
    assign bus.out_zero  = s2_q.zero;
    assign bus.out_inf   = s2_q.inf;
    assign bus.out_scale = s2_q.scale;
    assign bus.out_mant  = s2_q.mant;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Directed and randomized checks of the posit decode pipeline against hand values and a bitwise model.
module tb_posit_decode_pipe;
    import posit_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    posit_decode_pipe_if bus();

    posit_decode_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_out = 0;
    int last_iters = 0;

    logic [N-1:0]    feed_q[$];
    posit_unpacked_t feed_exp_q[$];
    posit_unpacked_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic posit_unpacked_t mk(input logic s, input logic z, input logic f,
                                           input int sc, input logic [MW-1:0] m);
        posit_unpacked_t r;
        r.sign  = s;
        r.zero  = z;
        r.inf   = f;
        r.scale = SW'(sc);
        r.mant  = m;
        return r;
    endfunction

    // Bit-walking reference decode
    function automatic posit_unpacked_t ref_decode(input logic [N-1:0] w);
        posit_unpacked_t r;
        logic [N-1:0] a;
        logic b;
        int i;
        int run;
        int k;
        int e;
        r = '0;
        if (w == '0) begin
            r.zero = 1'b1;
            return r;
        end
        if (w == NAR) begin
            r.inf = 1'b1;
            return r;
        end
        r.sign = w[N-1];
        a = w[N-1] ? (~w + 1) : w;
        b = a[N-2];
        i = N - 2;
        run = 0;
        while (i >= 0) begin
            if (a[i] != b) break;
            run++;
            i--;
        end
        k = b ? run - 1 : -run;
        i--;
        e = 0;
        for (int j = 0; j < int'(ES); j++) begin
            e = e * 2 + ((i >= 0) ? int'(a[i]) : 0);
            i--;
        end
        r.mant = '0;
        r.mant[MW-1] = 1'b1;
        for (int j = MW - 2; j >= 0; j--) begin
            r.mant[j] = (i >= 0) ? a[i] : 1'b0;
            i--;
        end
        r.scale = SW'(k * 4 + e);
        return r;
    endfunction

    task automatic chk_out(input string tag, input posit_unpacked_t e);
        chk({tag, ".sign"},  64'(bus.out_sign),  64'(e.sign));
        chk({tag, ".zero"},  64'(bus.out_zero),  64'(e.zero));
        chk({tag, ".inf"},   64'(bus.out_inf),   64'(e.inf));
        chk({tag, ".scale"}, 64'(bus.out_scale), 64'(e.scale));
        chk({tag, ".mant"},  64'(bus.out_mant),  64'(e.mant));
    endtask

    task automatic push(input logic [N-1:0] w, input posit_unpacked_t e);
        feed_q.push_back(w);
        feed_exp_q.push_back(e);
    endtask

    // iters > 0: run exactly that many cycles; iters == 0: run until drained, bounded
    task automatic run_cycles(input int iters, input int vp, input int rp, input string tag);
        int budget;
        int it;
        it = 0;
        budget = (iters > 0) ? iters : 100 + 20 * (feed_q.size() + exp_q.size());
        while (it < budget && (iters > 0 || feed_q.size() > 0 || exp_q.size() > 0)) begin
            bus.in_valid  = (feed_q.size() > 0) && ($urandom_range(99) < 32'(vp));
            bus.in_data   = (feed_q.size() > 0) ? feed_q[0] : '0;
            bus.out_ready = ($urandom_range(99) < 32'(rp));
            @(negedge clk);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk({tag, ".spurious"}, 64'(bus.out_valid), 64'(0));
                end else begin
                    chk_out(tag, exp_q[0]);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(feed_exp_q.pop_front());
                void'(feed_q.pop_front());
                n_acc++;
            end
            @(posedge clk);
            #1;
            it++;
        end
        last_iters = it;
        if (iters == 0 && (feed_q.size() > 0 || exp_q.size() > 0))
            chk({tag, ".timeout"}, 64'(feed_q.size() + exp_q.size()), 64'(0));
    endtask

    task automatic latency_test(input logic [N-1:0] w, input posit_unpacked_t e, input string tag);
        bus.in_valid  = 1'b1;
        bus.in_data   = w;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        @(negedge clk);
        chk({tag, ".lat1"}, 64'(bus.out_valid), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, ".lat2"}, 64'(bus.out_valid), 64'(1));
        chk_out(tag, e);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, ".drain"}, 64'(bus.out_valid), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        int acc0;
        int out0;
        logic [N-1:0] w;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst.in_ready",  64'(bus.in_ready),  64'(1));
        chk("rst.scale",     64'(bus.out_scale), 64'(0));
        chk("rst.mant",      64'(bus.out_mant),  64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word latency
        latency_test(32'h40000000, mk(0, 0, 0, 0, 28'h8000000), "one");

        // Back-to-back stream, one output per cycle
        push(32'h48000000, mk(0, 0, 0, 1,    28'h8000000));
        push(32'hC0000000, mk(1, 0, 0, 0,    28'h8000000));
        push(32'h7FFFFFFF, mk(0, 0, 0, 120,  28'h8000000));
        push(32'h00000001, mk(0, 0, 0, -120, 28'h8000000));
        out0 = n_out;
        run_cycles(0, 100, 100, "stream");
        chk("stream.cycles", 64'(last_iters), 64'(6));
        chk("stream.count",  64'(n_out - out0), 64'(4));

        // Specials and field boundaries
        push(32'h00000000, mk(0, 1, 0, 0,    28'h0));
        push(32'h80000000, mk(0, 0, 1, 0,    28'h0));
        push(32'hFFFFFFFF, mk(1, 0, 0, -120, 28'h8000000));
        push(32'h80000001, mk(1, 0, 0, 120,  28'h8000000));
        push(32'h3FFFFFFF, mk(0, 0, 0, -1,   28'hFFFFFFF));
        push(32'h7FFFFFFE, mk(0, 0, 0, 116,  28'h8000000));
        push(32'h50000000, mk(0, 0, 0, 2,    28'h8000000));
        run_cycles(0, 100, 100, "special");

        // Backpressure: two accepts then stall with stable outputs
        push(32'h40000000, mk(0, 0, 0, 0,  28'h8000000));
        push(32'h48000000, mk(0, 0, 0, 1,  28'h8000000));
        push(32'hC0000000, mk(1, 0, 0, 0,  28'h8000000));
        push(32'h3FFFFFFF, mk(0, 0, 0, -1, 28'hFFFFFFF));
        acc0 = n_acc;
        out0 = n_out;
        run_cycles(5, 100, 0, "bp");
        chk("bp.accepts", 64'(n_acc - acc0), 64'(2));
        @(negedge clk);
        chk("bp.in_ready",  64'(bus.in_ready),  64'(0));
        chk("bp.out_valid", 64'(bus.out_valid), 64'(1));
        @(posedge clk); #1;
        run_cycles(0, 100, 100, "bp_rel");
        chk("bp.outputs", 64'(n_out - out0), 64'(4));

        // Random traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(7))
                0:       w = 32'($urandom_range(255));
                1:       w = ~32'($urandom_range(255));
                2:       w = {1'b0, {31{1'b1}}} ^ 32'($urandom_range(255));
                default: w = $urandom;
            endcase
            push(w, ref_decode(w));
        end
        run_cycles(0, 70, 60, "rand");
        chk("rand.in_eq_out", 64'(n_acc), 64'(n_out));

        // Asynchronous reset with both stages full
        push(32'h40000000, mk(0, 0, 0, 0, 28'h8000000));
        push(32'h48000000, mk(0, 0, 0, 1, 28'h8000000));
        push(32'hC0000000, mk(1, 0, 0, 0, 28'h8000000));
        run_cycles(3, 100, 0, "rst_fill");
        chk("rstm.full", 64'(bus.in_ready), 64'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstm.out_valid", 64'(bus.out_valid), 64'(0));
        chk("rstm.in_ready",  64'(bus.in_ready),  64'(1));
        chk("rstm.mant",      64'(bus.out_mant),  64'(0));
        feed_q.delete();
        feed_exp_q.delete();
        exp_q.delete();
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        latency_test(32'h48000000, mk(0, 0, 0, 1, 28'h8000000), "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
